inst_mem: RTL and testbench
===========================

# inst_mem

Parametrised, loadable successor to the fixed instruction ROM. It holds the program in an on-chip array and serves registered instruction fetches to the core's fetch stage. It adds three things the fixed ROM does not have:
- a post-reset clear sweep;
- a streaming program-load port, so programs change without resynthesis;
- out-of-range address detection.

## Interface
Parameters:
- AW, 7, address width (InstAddress bits)
- DW, 9, instruction word width
- DEPTH, 128, number of stored words; 2 ≤ DEPTH ≤ 2**AW
- DEFAULT_WORD, 9'b100000000, fill value after clear and return value for invalid fetches

Ports:
- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- LoadStart  in  1  single-cycle request to begin a program load
- LoadValid  in  1  LoadData beat valid
- LoadData  in  DW  instruction word to write
- LoadLast  in  1  marks final beat of a load
- LoadReady  out  1  high while in LOAD; a beat is accepted when LoadValid & LoadReady
- LoadDone  out  1  one-cycle pulse when a load completes
- LoadCount  out  AW+1  number of words written by the most recent load
- Ready  out  1  high in IDLE; fetches accepted only when high
- FetchReq  in  1  fetch request
- InstAddress  in  AW  fetch address
- InstOut  out  DW  registered instruction
- InstValid  out  1  InstOut updated by a fetch accepted on the previous edge
- AddrErr  out  1  accompanies InstValid; high when the fetch address was ≥ DEPTH

## Operation
- States: CLEAR, IDLE, LOAD.
- Reset (Reset == 0 at an edge) from any state:
  - next state CLEAR, clear pointer = 0.
  - InstOut = DEFAULT_WORD.
  - InstValid, AddrErr, LoadReady, LoadDone, Ready = 0; LoadCount = 0.
- CLEAR:
  - writes DEFAULT_WORD to mem[ptr] and increments ptr, one word per cycle.
  - after writing DEPTH-1, goes to IDLE.
  - LoadStart and FetchReq are ignored.
- IDLE:
  - FetchReq reads mem[InstAddress] into InstOut and sets InstValid = 1 on the same edge.
  - If InstAddress ≥ DEPTH: InstOut = DEFAULT_WORD and AddrErr = 1.
  - With no FetchReq, InstValid = 0 and InstOut holds its value.
  - LoadStart goes to LOAD, with load pointer = 0 and LoadCount = 0.
- LOAD:
  - each accepted beat writes mem[ptr] = LoadData, then ptr++ and LoadCount++.
  - Exits to IDLE when the accepted beat has LoadLast = 1 or ptr == DEPTH-1. On exit, LoadDone pulses for one cycle, coincident with Ready rising.
  - Words beyond the last written address keep their prior contents; no re-clear.
  - FetchReq and repeated LoadStart are ignored.
- Simultaneous events:
  - LoadStart and FetchReq in the same IDLE cycle: both take effect. The fetch returns pre-load contents.
  - A LoadLast beat at ptr == DEPTH-1 is a single exit, not double-counted.
- Reset mid-LOAD or mid-CLEAR aborts the operation. No LoadDone pulse is generated. The full clear restarts.

## Timing
- Fetch latency is 1 cycle: request at edge N, with InstOut and InstValid valid after edge N.
- Throughput is one fetch per cycle in IDLE.
- The clear sweep takes DEPTH cycles. Ready first rises after the DEPTH-th edge following reset release.
- Load: LoadStart at edge N puts LoadReady high from edge N+1. The first beat is accepted at edge N+1 at the earliest.
- A load of k beats finishes with Ready = 1 and LoadDone = 1 after the edge accepting beat k.
- Back-to-back: LoadStart is accepted in the first IDLE cycle after LoadDone.

## Structure
- Package inst_mem_pkg holds:
  - the state enum (CLEAR, IDLE, LOAD);
  - the DEFAULT_WORD constant, shared with the assembler-side testbenches.
- Sub-module inst_mem_array holds the DEPTH×DW storage: one synchronous write port and one registered read port.
- The top-level holds the FSM, pointers and output flags.

## Test plan
- Reset, then wait 128 cycles → Ready = 0 throughout the sweep and rises at cycle 128. Fetch addresses 0, 4, 15, 127 → InstOut = 9'b100000000 for each, InstValid = 1, AddrErr = 0.
- Load 16 beats of data (i*3) mod 512 with LoadLast on beat 16:
  - LoadDone pulses once and LoadCount = 16.
  - Fetch 4 → 9'd12 and fetch 15 → 9'd45.
  - Fetch 16 → DEFAULT_WORD.
- Load 128 beats without LoadLast → auto-exit after beat 128 with LoadCount = 128. Fetch 127 → beat-127 data.
- With DEPTH = 100, fetch address 110 → InstOut = DEFAULT_WORD, AddrErr = 1. The next fetch of address 5 → AddrErr = 0.
- Assert FetchReq during LOAD and during CLEAR → InstValid stays 0. LoadStart and FetchReq(4) in the same IDLE cycle → InstOut returns the old mem[4], then LoadReady = 1.
- Reset after 5 load beats → no LoadDone pulse. A full 128-cycle clear follows, then fetch 2 → DEFAULT_WORD.

Source files
------------

// File: rtl/inst_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_pkg
// Brief    : Shared state encoding and fill word for the loadable inst memory.
// Revision : 1.0
// ============================================================================
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Also consumed by assembler-side benches as the "empty" instruction.
  localparam logic [8:0] DEFAULT_WORD = 9'b100000000;

endpackage
`default_nettype wire

// File: rtl/inst_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_array
// Brief    : DEPTH x DW storage, one synchronous write port, one registered read.
// Revision : 1.0
// ============================================================================
module inst_mem_array #(
  parameter int AW    = 7,
  parameter int DW    = 9,
  parameter int DEPTH = 128
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  import inst_mem_pkg::*;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Read and write never coincide: writes happen only outside IDLE.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem
// Brief    : Loadable instruction memory with clear sweep and range checking.
// Revision : 1.0
// ============================================================================
module inst_mem #(
  parameter int            AW           = 7,
  parameter int            DW           = 9,
  parameter int            DEPTH        = 128,
  parameter logic [DW-1:0] DEFAULT_WORD = DW'(inst_mem_pkg::DEFAULT_WORD)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadStart,
  input  logic          LoadValid,
  input  logic [DW-1:0] LoadData,
  input  logic          LoadLast,
  output logic          LoadReady,
  output logic          LoadDone,
  output logic [AW:0]   LoadCount,
  output logic          Ready,
  input  logic          FetchReq,
  input  logic [AW-1:0] InstAddress,
  output logic [DW-1:0] InstOut,
  output logic          InstValid,
  output logic          AddrErr
);
  import inst_mem_pkg::*;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic          ready_q, ready_d;
  logic          load_ready_q, load_ready_d;
  logic          load_done_q, load_done_d;
  logic          inst_valid_q, inst_valid_d;
  logic          addr_err_q, addr_err_d;
  logic          use_default_q, use_default_d;

  logic          addr_in_range;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          rd_en;
  logic [DW-1:0] rd_data;

  assign addr_in_range = ({1'b0, InstAddress} < DEPTH_W);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    load_count_d  = load_count_q;
    load_done_d   = 1'b0;
    inst_valid_d  = 1'b0;
    addr_err_d    = 1'b0;
    use_default_d = use_default_q;
    mem_we        = 1'b0;
    mem_wdata     = LoadData;
    rd_en         = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = DEFAULT_WORD;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        // Out-of-range fetches skip the array and return the fill word instead.
        if (FetchReq) begin
          inst_valid_d  = 1'b1;
          addr_err_d    = ~addr_in_range;
          use_default_d = ~addr_in_range;
          rd_en         = addr_in_range;
        end
        if (LoadStart) begin
          state_d      = ST_LOAD;
          ptr_d        = '0;
          load_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (LoadValid) begin
          mem_we       = 1'b1;
          ptr_d        = ptr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
          if (LoadLast || (ptr_q == LAST_PTR)) begin
            state_d     = ST_IDLE;
            ptr_d       = '0;
            load_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
    ready_d      = (state_d == ST_IDLE);
    load_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q       <= ST_CLEAR;
      ptr_q         <= '0;
      load_count_q  <= '0;
      ready_q       <= 1'b0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      inst_valid_q  <= 1'b0;
      addr_err_q    <= 1'b0;
      use_default_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      load_count_q  <= load_count_d;
      ready_q       <= ready_d;
      load_ready_q  <= load_ready_d;
      load_done_q   <= load_done_d;
      inst_valid_q  <= inst_valid_d;
      addr_err_q    <= addr_err_d;
      use_default_q <= use_default_d;
    end
  end

  inst_mem_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .Clk   (Clk),
    .we    (mem_we & Reset),
    .waddr (ptr_q),
    .wdata (mem_wdata),
    .re    (rd_en & Reset),
    .raddr (InstAddress),
    .rdata (rd_data)
  );

  assign InstOut   = use_default_q ? DEFAULT_WORD : rd_data;
  assign InstValid = inst_valid_q;
  assign AddrErr   = addr_err_q;
  assign Ready     = ready_q;
  assign LoadReady = load_ready_q;
  assign LoadDone  = load_done_q;
  assign LoadCount = load_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem
// Brief    : Self-checking bench for inst_mem (DEPTH 128 plus a DEPTH 100 copy).
// Revision : 1.0
// ============================================================================
module tb_inst_mem;
  localparam int AW      = 7;
  localparam int DW      = 9;
  localparam int DEPTH   = 128;
  localparam int DEPTH_B = 100;
  localparam logic [DW-1:0] DEF = 9'b100000000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } vec_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          LoadStart = 1'b0, LoadValid = 1'b0, LoadLast = 1'b0;
  logic [DW-1:0] LoadData = '0;
  logic          LoadReady, LoadDone, Ready, InstValid, AddrErr;
  logic [AW:0]   LoadCount;
  logic          FetchReq = 1'b0;
  logic [AW-1:0] InstAddress = '0;
  logic [DW-1:0] InstOut;

  logic          b_load_start = 1'b0, b_load_valid = 1'b0, b_load_last = 1'b0;
  logic [DW-1:0] b_load_data = '0;
  logic          b_load_ready, b_load_done, b_ready, b_inst_valid, b_addr_err;
  logic [AW:0]   b_load_count;
  logic          b_fetch_req = 1'b0;
  logic [AW-1:0] b_inst_address = '0;
  logic [DW-1:0] b_inst_out;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_mem [DEPTH];
  vec_t tbl [3];

  always #5 Clk = ~Clk;

  inst_mem #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .DEFAULT_WORD(DEF)) dut (
    .Clk(Clk), .Reset(Reset), .LoadStart(LoadStart), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(LoadReady),
    .LoadDone(LoadDone), .LoadCount(LoadCount), .Ready(Ready),
    .FetchReq(FetchReq), .InstAddress(InstAddress), .InstOut(InstOut),
    .InstValid(InstValid), .AddrErr(AddrErr)
  );

  inst_mem #(.AW(AW), .DW(DW), .DEPTH(DEPTH_B), .DEFAULT_WORD(DEF)) dut_b (
    .Clk(Clk), .Reset(Reset), .LoadStart(b_load_start), .LoadValid(b_load_valid),
    .LoadData(b_load_data), .LoadLast(b_load_last), .LoadReady(b_load_ready),
    .LoadDone(b_load_done), .LoadCount(b_load_count), .Ready(b_ready),
    .FetchReq(b_fetch_req), .InstAddress(b_inst_address), .InstOut(b_inst_out),
    .InstValid(b_inst_valid), .AddrErr(b_addr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Holds reset, releases it, and times the clear sweep on both instances
  // while fetch and load requests are held high (they must be ignored).
  task automatic reset_and_sweep(input int hold);
    int early, vseen, dones;
    Reset = 1'b0; FetchReq = 1'b1; InstAddress = 7'd4; LoadStart = 1'b1;
    LoadValid = 1'b0; LoadLast = 1'b0;
    repeat (hold) step();
    chk("rst_instout", InstOut, DEF);
    chk("rst_instvalid", InstValid, 0);
    chk("rst_addrerr", AddrErr, 0);
    chk("rst_ready", Ready, 0);
    chk("rst_loadready", LoadReady, 0);
    chk("rst_loaddone", LoadDone, 0);
    chk("rst_loadcount", LoadCount, 0);
    Reset = 1'b1;
    early = 0; vseen = 0; dones = 0;
    for (int c = 1; c <= DEPTH; c++) begin
      step();
      if (c < DEPTH && Ready) early++;
      if (InstValid || LoadReady) vseen++;
      if (LoadDone) dones++;
      if (c == DEPTH_B - 1) chk("b_ready_before", b_ready, 0);
      if (c == DEPTH_B) chk("b_ready_rise", b_ready, 1);
    end
    chk("sweep_ready_early", early, 0);
    chk("sweep_ready_rise", Ready, 1);
    chk("sweep_reqs_ignored", vseen, 0);
    chk("sweep_no_done", dones, 0);
    FetchReq = 1'b0; LoadStart = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = DEF;
  endtask

  task automatic fetch(input string name, input logic [AW-1:0] addr,
                       input logic [DW-1:0] exp_data, input logic exp_err);
    FetchReq = 1'b1; InstAddress = addr;
    step();
    FetchReq = 1'b0;
    chk({name, "_valid"}, InstValid, 1);
    chk({name, "_data"}, InstOut, exp_data);
    chk({name, "_err"}, AddrErr, exp_err);
  endtask

  task automatic fetch_b(input string name, input logic [AW-1:0] addr,
                         input logic [DW-1:0] exp_data, input logic exp_err);
    b_fetch_req = 1'b1; b_inst_address = addr;
    step();
    b_fetch_req = 1'b0;
    chk({name, "_valid"}, b_inst_valid, 1);
    chk({name, "_data"}, b_inst_out, exp_data);
    chk({name, "_err"}, b_addr_err, exp_err);
  endtask

  // pattern 0 writes (i*3) mod 512; otherwise random words.
  task automatic do_load(input int n, input bit use_last, input bit noise,
                         input int pattern);
    int mid_err, vseen;
    logic [DW-1:0] d;
    LoadStart = 1'b1; FetchReq = 1'b0;
    step();
    chk("ld_start_loadready", LoadReady, 1);
    chk("ld_start_ready", Ready, 0);
    chk("ld_start_done_low", LoadDone, 0);
    chk("ld_start_count", LoadCount, 0);
    LoadStart = noise;
    mid_err = 0; vseen = 0;
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          LoadValid = 1'b0; FetchReq = 1'b1; InstAddress = 7'($urandom_range(0, 127));
          step();
          if (LoadDone || !LoadReady) mid_err++;
          if (InstValid) vseen++;
        end
      end
      d = (pattern == 0) ? DW'((i * 3) % 512) : DW'($urandom);
      LoadValid = 1'b1; LoadData = d; LoadLast = use_last && (i == n - 1);
      FetchReq = noise; InstAddress = 7'($urandom_range(0, 127));
      step();
      model_mem[i] = d;
      if (i < n - 1 && (LoadDone || !LoadReady)) mid_err++;
      if (InstValid) vseen++;
    end
    LoadValid = 1'b0; LoadLast = 1'b0; FetchReq = 1'b0; LoadStart = 1'b0;
    chk("ld_mid", mid_err, 0);
    chk("ld_fetch_ignored", vseen, 0);
    chk("ld_done", LoadDone, 1);
    chk("ld_ready", Ready, 1);
    chk("ld_loadready_low", LoadReady, 0);
    chk("ld_count", LoadCount, n);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    reset_and_sweep(3);

    tbl[0] = '{7'd0, DEF, 1'b0};
    tbl[1] = '{7'd4, DEF, 1'b0};
    tbl[2] = '{7'd15, DEF, 1'b0};
    for (int i = 0; i < 3; i++) fetch("t1_fetch", tbl[i].addr, tbl[i].data, tbl[i].err);
    fetch("t1_fetch127", 7'd127, DEF, 1'b0);

    do_load(16, 1'b1, 1'b0, 0);
    tbl[0] = '{7'd4, 9'd12, 1'b0};
    tbl[1] = '{7'd16, DEF, 1'b0};
    tbl[2] = '{7'd15, 9'd45, 1'b0};
    for (int i = 0; i < 3; i++) fetch("t2_fetch", tbl[i].addr, tbl[i].data, tbl[i].err);
    step();
    chk("hold_valid", InstValid, 0);
    chk("hold_data", InstOut, 9'd45);

    do_load(DEPTH, 1'b0, 1'b1, 1);
    fetch("full_fetch127", 7'd127, model_mem[127], 1'b0);
    for (int i = 0; i < 30; i++) begin
      a = 7'($urandom_range(0, DEPTH - 1));
      fetch("rand_fetch", a, model_mem[a], 1'b0);
    end

    LoadStart = 1'b1; FetchReq = 1'b1; InstAddress = 7'd4;
    step();
    LoadStart = 1'b0; FetchReq = 1'b0;
    chk("combo_valid", InstValid, 1);
    chk("combo_old_data", InstOut, model_mem[4]);
    chk("combo_loadready", LoadReady, 1);
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom);
      LoadValid = 1'b1; LoadData = d; LoadLast = (i == 2);
      step();
      model_mem[i] = d;
    end
    LoadValid = 1'b0; LoadLast = 1'b0;
    chk("combo_done", LoadDone, 1);
    chk("combo_count", LoadCount, 3);
    do_load(5, 1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) fetch("b2b_fetch", 7'(i), model_mem[i], 1'b0);

    tbl[0] = '{7'd110, DEF, 1'b1};
    tbl[1] = '{7'd5, DEF, 1'b0};
    tbl[2] = '{7'd99, DEF, 1'b0};
    for (int i = 0; i < 3; i++) fetch_b("b_fetch", tbl[i].addr, tbl[i].data, tbl[i].err);
    fetch_b("b_fetch100", 7'd100, DEF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      a = 7'($urandom_range(0, 127));
      fetch_b("b_rand", a, DEF, (int'(a) >= DEPTH_B));
    end

    LoadStart = 1'b1;
    step();
    LoadStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      LoadValid = 1'b1; LoadData = DW'(i + 7); LoadLast = 1'b0;
      step();
    end
    LoadValid = 1'b0;
    chk("abort_no_done_before", LoadDone, 0);
    reset_and_sweep(1);
    fetch("abort_fetch2", 7'd2, DEF, 1'b0);
    fetch("abort_fetch4", 7'd4, DEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
